// File: rtl/l2_port_rr_arbiter_if.sv
// L1/L2 side signal bundle for the shared L2 port arbiter.
// slave = arbiter view, master = surrounding caches / environment.
interface l2_port_rr_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  icache_read;
    logic [ADDR_WIDTH-1:0] icache_address;
    logic [LINE_WIDTH-1:0] icache_rdata;
    logic                  icache_resp;

    logic                  dcache_read;
    logic                  dcache_write;
    logic [ADDR_WIDTH-1:0] dcache_address;
    logic [LINE_WIDTH-1:0] dcache_wdata;
    logic [LINE_WIDTH-1:0] dcache_rdata;
    logic                  dcache_resp;

    logic                  l2_read;
    logic                  l2_write;
    logic [ADDR_WIDTH-1:0] l2_address;
    logic [LINE_WIDTH-1:0] l2_wdata;
    logic [LINE_WIDTH-1:0] l2_rdata;
    logic                  l2_resp;

    modport slave (
        input  icache_read, icache_address,
        output icache_rdata, icache_resp,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        output dcache_rdata, dcache_resp,
        output l2_read, l2_write, l2_address, l2_wdata,
        input  l2_rdata, l2_resp
    );

    modport master (
        output icache_read, icache_address,
        input  icache_rdata, icache_resp,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  dcache_rdata, dcache_resp,
        input  l2_read, l2_write, l2_address, l2_wdata,
        output l2_rdata, l2_resp
    );
endinterface

// File: rtl/l2_port_rr_arbiter.sv
// Round-robin arbiter sharing one L2 port between L1 icache and dcache.
// One L2 command in flight; the returned line is registered and the completion pulse routed to the granted requester.
module l2_port_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    l2_port_rr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, L2_IREAD, L2_DREAD, L2_DWRITE} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] wdata;
    } req_t;

    state_t                state_q, state_d;
    logic                  resp_q, resp_d;
    logic                  tgt_q, tgt_d;     // 1 = dcache owns the pending resp
    logic                  last_q, last_d;   // 1 = dcache granted most recently
    req_t                  req_q, req_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

    logic dreq, ireq, pick_d;

    assign dreq   = bus.dcache_read | bus.dcache_write;
    assign ireq   = bus.icache_read;
    // dcache wins contention only when icache was served last
    assign pick_d = dreq & (~ireq | ~last_q);

    always_comb begin
        state_d = state_q;
        resp_d  = 1'b0;
        tgt_d   = tgt_q;
        last_d  = last_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // the respond cycle never grants, so a held request re-arbitrates afterwards
                if (!resp_q) begin
                    if (pick_d) begin
                        req_d.addr = bus.dcache_address;
                        last_d     = 1'b1;
                        if (bus.dcache_write) begin
                            req_d.wdata = bus.dcache_wdata;
                            state_d     = L2_DWRITE;
                        end else begin
                            state_d = L2_DREAD;
                        end
                    end else if (ireq) begin
                        req_d.addr = bus.icache_address;
                        last_d     = 1'b0;
                        state_d    = L2_IREAD;
                    end
                end
            end
            L2_IREAD, L2_DREAD: begin
                if (bus.l2_resp) begin
                    rdata_d = bus.l2_rdata;
                    resp_d  = 1'b1;
                    tgt_d   = (state_q == L2_DREAD);
                    state_d = IDLE;
                end
            end
            L2_DWRITE: begin
                if (bus.l2_resp) begin
                    resp_d  = 1'b1;
                    tgt_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            resp_q  <= 1'b0;
            tgt_q   <= 1'b0;
            last_q  <= 1'b1;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            tgt_q   <= tgt_d;
            last_q  <= last_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.l2_read      = (state_q == L2_IREAD) || (state_q == L2_DREAD);
    assign bus.l2_write     = (state_q == L2_DWRITE);
    assign bus.l2_address   = req_q.addr;
    assign bus.l2_wdata     = req_q.wdata;
    assign bus.icache_resp  = resp_q & ~tgt_q;
    assign bus.dcache_resp  = resp_q &  tgt_q;
    assign bus.icache_rdata = rdata_q;
    assign bus.dcache_rdata = rdata_q;
endmodule

// File: doc/l2_port_rr_arbiter.md
# l2_port_rr_arbiter

Registered round-robin arbiter that shares the single L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write). It captures the granted request's address and write line, drives one L2 transaction at a time, buffers the returned line, and routes a one-cycle response back to the requester that was granted. It sits between the split L1 caches and the unified L2. It replaces fixed data-first priority with alternating priority, so instruction fetch cannot be starved under back-to-back data misses.

## Interface
- ADDR_WIDTH, 32, L1/L2 byte address width
- LINE_WIDTH, 256, cache line width in bits
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- icache_read  in  1  instruction line read request, level, held until icache_resp
- icache_address  in  ADDR_WIDTH  instruction line address
- icache_rdata  out  LINE_WIDTH  returned instruction line, valid while icache_resp=1
- icache_resp  out  1  one-cycle completion pulse to icache
- dcache_read  in  1  data line read request, level, held until dcache_resp
- dcache_write  in  1  data line write-back request, level, held until dcache_resp
- dcache_address  in  ADDR_WIDTH  data line address
- dcache_wdata  in  LINE_WIDTH  write-back line
- dcache_rdata  out  LINE_WIDTH  returned data line, valid while dcache_resp=1
- dcache_resp  out  1  one-cycle completion pulse to dcache
- l2_read, l2_write  out  1  L2 command, held until l2_resp
- l2_address  out  ADDR_WIDTH  registered address of the granted request
- l2_wdata  out  LINE_WIDTH  registered write line
- l2_rdata  in  LINE_WIDTH  L2 read line, valid with l2_resp
- l2_resp  in  1  L2 completion, one cycle

## Operation
- State register has four states: IDLE, L2_IREAD, L2_DREAD, L2_DWRITE. It also holds a RESP flag (single-cycle respond phase) and last_grant (0 = icache, 1 = dcache).
- Datapath registers:
  - addr_q: captured at grant, drives l2_address.
  - wdata_q: captured from dcache_wdata on a dcache write grant, drives l2_wdata.
  - rdata_q: captured from l2_rdata when l2_resp=1 in a read state, drives both icache_rdata and dcache_rdata.
- IDLE (RESP=0), request evaluation:
  - dreq = dcache_read | dcache_write; ireq = icache_read.
  - Only one of them asserted: grant it.
  - Both asserted: grant dcache if last_grant=0, otherwise grant icache.
  - A dcache grant goes to L2_DWRITE if dcache_write=1, else L2_DREAD. dcache_read and dcache_write both high is a protocol violation; write wins.
  - On grant: load addr_q (and wdata_q for a write), update last_grant, move to the issue state.
- L2_IREAD / L2_DREAD: assert l2_read.
  - On l2_resp: load rdata_q, set RESP, record the target, return to IDLE.
- L2_DWRITE: assert l2_write.
  - On l2_resp: set RESP, return to IDLE. rdata_q is unchanged.
- RESP cycle (state IDLE, RESP=1):
  - Pulse icache_resp or dcache_resp (target only) for exactly one cycle.
  - No grant is made in this cycle; RESP clears at the next edge.
  - The requester is required to drop its request in the cycle after its resp. A request that is still high in the following IDLE cycle is treated as a new request.
- l2_address and l2_wdata hold stable for the entire L2 command; input changes after grant are ignored.
- At most one L2 command is outstanding. l2_read and l2_write are never both high.

## Timing
- Reset values:
  - State IDLE, RESP=0, last_grant=1 (icache wins the first contention).
  - addr_q, wdata_q and rdata_q = 0.
  - All resp, l2_read and l2_write outputs = 0.
- Reset mid-transaction abandons the L2 command the next cycle and produces no resp pulse.
- Grant latency: request sampled in IDLE at cycle 0; L2 command asserted from cycle 1.
- Response latency: l2_resp at cycle k gives the L1 resp and rdata at cycle k+1 (registered).
- Minimum round trip: request at 0, l2_resp at 1, L1 resp at 2, next grant evaluated at 3.
- l2_resp received while in IDLE is ignored.

## Test plan
- Single icache read at address 0x0000_1000, L2 responds after 3 cycles with line 0xA5…A5:
  - l2_read high during cycles 1–3, l2_address = 0x1000.
  - icache_resp pulses at cycle 4 with icache_rdata = 0xA5…A5; dcache_resp stays 0.
- dcache write at 0x0000_2040 with wdata 0x1234…:
  - l2_write held with l2_address and l2_wdata stable until l2_resp.
  - dcache_resp is one cycle; rdata_q is unchanged.
- icache and dcache requesting simultaneously from reset, each re-requesting immediately after its resp:
  - Grants alternate I, D, I, D, starting with I after reset.
  - Neither requester waits more than one transaction.
- dcache_address and dcache_wdata changed during an outstanding write: l2_address and l2_wdata keep the values captured at grant.
- reset asserted while in L2_DREAD waiting for l2_resp:
  - Next cycle is IDLE with all outputs 0 and no dcache_resp.
  - A late l2_resp arriving after reset is ignored.
- dcache_read and dcache_write both high: L2_DWRITE is taken (l2_write=1, l2_read=0).
